ts_cc_monitor: RTL and testbench
================================

// Module: ts_cc_monitor
// PURPOSE
//  Downstream of the TS sync-recovery stage: consumes the sync-locked byte stream
//  and its packet-start pulse, and parses each 188-byte packet header
//  (TEI, PUSI, PID, AFC, CC). It tracks the continuity counter per PID in a small
//  learned table. It flags CC errors, TEI errors and framing loss for the QoS
//  monitor (TR 101 290 priority-1 style checks).
// PARAMETERS
//  NUM_PIDS  8   PID tracking table entries; 1..16
//  CNT_W     16  width of the saturating statistic counters
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset, asynchronous, active-low
//  byte_in       in   8      stream byte, already delayed and aligned by upstream sync stage
//  byte_valid    in   1      byte_in qualifier; nothing advances when low
//  pkt_start     in   1      upstream valid_packet; high with the 0x47 byte of a locked packet
//  clr_stats     in   1      synchronous clear of the counters and the PID table
//  hdr_valid     out  1      1-cycle pulse: pid/cc/pusi/tei below are valid
//  pid           out  13     PID of the last parsed header
//  cc            out  4      continuity counter of the last parsed header
//  pusi          out  1      payload_unit_start_indicator of the last header
//  tei           out  1      transport_error_indicator of the last header
//  cc_err        out  1      1-cycle pulse, coincident with hdr_valid
//  sync_loss     out  1      1-cycle pulse: expected sync byte missing, or packet cut short
//  table_full    out  1      level: untracked PID seen while every slot was in use; cleared only by clr_stats
//  pkt_count     out  CNT_W  saturating count of parsed headers
//  cc_err_count  out  CNT_W  saturating count of cc_err pulses
//  tei_count     out  CNT_W  saturating count of headers with tei=1
// BEHAVIOUR
//  Reset: FSM=IDLE, all outputs 0, all table entries invalid.
//  Accepted byte: byte_valid=1. Every FSM step below consumes one accepted byte.
//  FSM:
//   IDLE   leaves on pkt_start & byte_in==8'h47 -> H1; everything else is ignored.
//   H1     tei=b[7], pusi=b[6], pid[12:8]=b[4:0]; -> H2
//   H2     pid[7:0]=b; -> H3
//   H3     afc=b[5:4], cc=b[3:0]; registers the lookup; -> PAY with byte_cnt=4
//   PAY    byte_cnt++ each byte; at byte_cnt==187 -> CHK
//   CHK    next accepted byte: pkt_start & 8'h47 -> H1; else sync_loss pulse -> IDLE
//  pkt_start seen in H1..PAY (packet cut short): sync_loss pulse, then treat that byte
//   as a new sync byte -> H1.
//  Header outputs, hdr_valid, cc_err and counter updates appear on the clock edge
//   after the H3 byte is accepted (latency 1).
//  CC check (pid!=13'h1FFF; null PID never checked or stored):
//   Lookup is over valid entries {pid, last_cc, dup_seen}.
//   Miss with a free slot: allocate the lowest free index; no error.
//   Miss with no free slot: set table_full; no error.
//   Hit, afc in {00,10} (no payload): expect cc==last_cc; mismatch -> cc_err.
//   Hit, afc in {01,11} (payload): cc==last_cc+1 mod 16 -> ok, clear dup_seen.
//    cc==last_cc with dup_seen=0 -> ok (one duplicate), set dup_seen.
//    Any other value -> cc_err, clear dup_seen.
//   On a hit, last_cc<=cc in every case, including on error.
//   Wrap: last_cc=15 expects 0.
//  Counters saturate at all-ones. clr_stats has priority over a same-cycle increment
//   and over a same-cycle table write; the header still outputs and hdr_valid still pulses.
//  Reset mid-packet: immediate return to IDLE; the table is lost.
// TESTING
//  1. Reset, then 4 clean packets PID=0x100, afc=01, cc=0..3
//     -> 4 hdr_valid, pkt_count=4, cc_err never, pid=0x100.
//  2. PID 0x100 cc sequence 5,6,6,6
//     -> 3rd packet ok (first duplicate), 4th cc_err; cc_err_count=1.
//  3. cc 14,15,0 with afc=01 -> no error (wrap). afc=10 with cc changed 3->4 -> cc_err.
//  4. Insert 9 distinct PIDs with NUM_PIDS=8 -> table_full=1 on the 9th header,
//     no cc_err. PID 0x1FFF -> hdr_valid only, table untouched.
//  5. Corrupt the sync byte of the 3rd packet (0x46) -> sync_loss pulse, FSM IDLE,
//     no hdr_valid until the next pkt_start & 0x47.
//  6. pkt_start mid-payload at byte 100 -> sync_loss, new header parsed.
//     clr_stats asserted with hdr_valid -> counters 0.

Source files
------------

// File: rtl/ts_cc_monitor.sv
// TS header parser and per-PID continuity-counter checker.
// Sits behind sync recovery; reports CC/TEI errors and framing loss.
module ts_cc_monitor #(
    parameter int NUM_PIDS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             pkt_start,
    input  logic             clr_stats,
    output logic             hdr_valid,
    output logic [12:0]      pid,
    output logic [3:0]       cc,
    output logic             pusi,
    output logic             tei,
    output logic             cc_err,
    output logic             sync_loss,
    output logic             table_full,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] cc_err_count,
    output logic [CNT_W-1:0] tei_count
);

    localparam int IW = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;

    typedef enum logic [2:0] {
        IDLE, H1, H2, H3, PAY, CHK
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic        sync_d;
    logic        hdr_go;
    logic        is_sync;

    logic        cur_tei;
    logic        cur_pusi;
    logic [12:0] cur_pid;

    logic              tbl_vld [NUM_PIDS];
    logic [12:0]       tbl_pid [NUM_PIDS];
    logic [3:0]        tbl_cc  [NUM_PIDS];
    logic              tbl_dup [NUM_PIDS];

    logic          hit;
    logic          has_free;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] free_idx;
    logic [3:0]    new_cc;
    logic [1:0]    new_afc;
    logic [3:0]    last_cc;
    logic          last_dup;
    logic          is_null;
    logic          chk_err;
    logic          chk_dup;
    logic          err_d;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign is_sync = pkt_start && (byte_in == 8'h47);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        sync_d     = 1'b0;
        hdr_go     = 1'b0;
        if (byte_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (is_sync)
                        state_d = H1;
                end
                H1, H2, H3, PAY: begin
                    // a start inside a packet means it was cut short
                    if (pkt_start) begin
                        sync_d  = 1'b1;
                        state_d = H1;
                    end else begin
                        unique case (state_q)
                            H1: state_d = H2;
                            H2: state_d = H3;
                            H3: begin
                                hdr_go     = 1'b1;
                                state_d    = PAY;
                                byte_cnt_d = 8'd4;
                            end
                            default: begin
                                byte_cnt_d = byte_cnt_q + 8'd1;
                                if (byte_cnt_q == 8'd187)
                                    state_d = CHK;
                            end
                        endcase
                    end
                end
                CHK: begin
                    if (is_sync) begin
                        state_d = H1;
                    end else begin
                        sync_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_tei  <= 1'b0;
            cur_pusi <= 1'b0;
            cur_pid  <= '0;
        end else if (byte_valid && !pkt_start) begin
            if (state_q == H1) begin
                cur_tei       <= byte_in[7];
                cur_pusi      <= byte_in[6];
                cur_pid[12:8] <= byte_in[4:0];
            end
            if (state_q == H2)
                cur_pid[7:0] <= byte_in;
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        // descending scan so the lowest free slot wins
        for (int i = NUM_PIDS - 1; i >= 0; i--) begin
            if (tbl_vld[i] && tbl_pid[i] == cur_pid) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!tbl_vld[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign new_cc   = byte_in[3:0];
    assign new_afc  = byte_in[5:4];
    assign last_cc  = tbl_cc[hit_idx];
    assign last_dup = tbl_dup[hit_idx];
    assign is_null  = (cur_pid == 13'h1FFF);

    always_comb begin
        chk_err = 1'b0;
        chk_dup = last_dup;
        if (!new_afc[0]) begin
            chk_err = (new_cc != last_cc);
        end else if (new_cc == last_cc + 4'd1) begin
            chk_dup = 1'b0;
        end else if (new_cc == last_cc && !last_dup) begin
            chk_dup = 1'b1;
        end else begin
            chk_err = 1'b1;
            chk_dup = 1'b0;
        end
    end

    assign err_d = hit && !is_null && chk_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_valid    <= 1'b0;
            pid          <= '0;
            cc           <= '0;
            pusi         <= 1'b0;
            tei          <= 1'b0;
            cc_err       <= 1'b0;
            sync_loss    <= 1'b0;
            table_full   <= 1'b0;
            pkt_count    <= '0;
            cc_err_count <= '0;
            tei_count    <= '0;
            for (int i = 0; i < NUM_PIDS; i++) begin
                tbl_vld[i] <= 1'b0;
                tbl_pid[i] <= '0;
                tbl_cc[i]  <= '0;
                tbl_dup[i] <= 1'b0;
            end
        end else begin
            hdr_valid <= 1'b0;
            cc_err    <= 1'b0;
            sync_loss <= sync_d;
            if (hdr_go) begin
                hdr_valid <= 1'b1;
                pid       <= cur_pid;
                cc        <= new_cc;
                pusi      <= cur_pusi;
                tei       <= cur_tei;
                cc_err    <= err_d;
            end
            if (clr_stats) begin
                table_full   <= 1'b0;
                pkt_count    <= '0;
                cc_err_count <= '0;
                tei_count    <= '0;
                for (int i = 0; i < NUM_PIDS; i++)
                    tbl_vld[i] <= 1'b0;
            end else if (hdr_go) begin
                pkt_count <= sat_inc(pkt_count);
                if (err_d)
                    cc_err_count <= sat_inc(cc_err_count);
                if (cur_tei)
                    tei_count <= sat_inc(tei_count);
                if (!is_null) begin
                    if (hit) begin
                        tbl_cc[hit_idx]  <= new_cc;
                        tbl_dup[hit_idx] <= chk_dup;
                    end else if (has_free) begin
                        tbl_vld[free_idx] <= 1'b1;
                        tbl_pid[free_idx] <= cur_pid;
                        tbl_cc[free_idx]  <= new_cc;
                        tbl_dup[free_idx] <= 1'b0;
                    end else begin
                        table_full <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ts_cc_monitor.sv
// Scoreboard bench for ts_cc_monitor with a packet-level reference model.
// Directed scenarios followed by randomized packets, gaps and faults.
module tb_ts_cc_monitor;

    localparam int NP = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          pkt_start = 1'b0;
    logic          clr_stats = 1'b0;
    logic          hdr_valid;
    logic [12:0]   pid;
    logic [3:0]    cc;
    logic          pusi;
    logic          tei;
    logic          cc_err;
    logic          sync_loss;
    logic          table_full;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] cc_err_count;
    logic [CW-1:0] tei_count;

    ts_cc_monitor #(.NUM_PIDS(NP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in),
        .byte_valid(byte_valid), .pkt_start(pkt_start),
        .clr_stats(clr_stats), .hdr_valid(hdr_valid),
        .pid(pid), .cc(cc), .pusi(pusi), .tei(tei),
        .cc_err(cc_err), .sync_loss(sync_loss),
        .table_full(table_full), .pkt_count(pkt_count),
        .cc_err_count(cc_err_count), .tei_count(tei_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0]   pid;
        logic [3:0]    cc;
        logic          pusi;
        logic          tei;
        logic          err;
        logic          full;
        logic [CW-1:0] pc;
        logic [CW-1:0] ec;
        logic [CW-1:0] tc;
    } hdr_t;

    hdr_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   sync_exp = 0;
    int   sync_seen = 0;

    int   mcc[int];
    bit   mdup[int];
    bit   mfull;
    int   mpc, mec, mtc;
    bit   in_chk, pend_cut;

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void m_clear();
        mcc.delete();
        mdup.delete();
        mfull = 0;
        mpc = 0;
        mec = 0;
        mtc = 0;
    endfunction

    function automatic hdr_t m_hdr(input int p, input int c, input int afc,
                                   input bit t, input bit u, input bit clr);
        hdr_t r;
        bit   e = 0;
        if (p != 13'h1FFF) begin
            if (mcc.exists(p)) begin
                int l = mcc[p];
                if (afc % 2 == 0) e = (c != l);
                else if (c == (l + 1) % 16) mdup[p] = 0;
                else if (c == l && !mdup[p]) mdup[p] = 1;
                else begin
                    e = 1;
                    mdup[p] = 0;
                end
                mcc[p] = c;
            end else if (mcc.num() < NP) begin
                mcc[p] = c;
                mdup[p] = 0;
            end else begin
                mfull = 1;
            end
        end
        if (clr) m_clear();
        else begin
            mpc++;
            if (e) mec++;
            if (t) mtc++;
        end
        r.pid = 13'(p);
        r.cc = 4'(c);
        r.pusi = u;
        r.tei = t;
        r.err = e;
        r.full = mfull;
        r.pc = CW'(mpc);
        r.ec = CW'(mec);
        r.tc = CW'(mtc);
        return r;
    endfunction

    task automatic put(input logic [7:0] b, input logic ps, input logic cl);
        while ($urandom_range(7) == 0) begin
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
            pkt_start = 1'($urandom_range(1));
            clr_stats = 1'b0;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_in = b;
        pkt_start = ps;
        clr_stats = cl;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        pkt_start = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic send_pkt(input int p, input int c, input int afc,
                            input bit t, input bit u, input logic [7:0] sb_in,
                            input int cut, input bit clr);
        logic [12:0] pp;
        logic [7:0]  sb;
        logic [7:0]  b;
        bit          parse;
        bit          cl;
        pp = 13'(p);
        sb = pend_cut ? 8'h47 : sb_in;
        if (pend_cut) begin
            sync_exp++;
            parse = 1;
        end else if (in_chk) begin
            parse = (sb == 8'h47);
            if (!parse) sync_exp++;
        end else begin
            parse = (sb == 8'h47);
        end
        for (int i = 0; i < cut; i++) begin
            cl = 0;
            case (i)
                0: b = sb;
                1: b = {t, u, 1'b0, pp[12:8]};
                2: b = pp[7:0];
                3: begin
                    b = {2'b00, 2'(afc), 4'(c)};
                    if (parse) begin
                        sbq.push_back(m_hdr(p, c, afc, t, u, clr));
                        cl = clr;
                    end
                end
                default: b = 8'($urandom);
            endcase
            put(b, i == 0, cl);
        end
        in_chk = parse && cut == 188;
        pend_cut = parse && cut < 188;
    endtask

    task automatic pulse_clr();
        byte_valid = 1'b0;
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        m_clear();
    endtask

    task automatic drain(input string name);
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_queue"}, 80'(sbq.size()), 80'(0));
        chk({name, "_sync"}, 80'(sync_seen), 80'(sync_exp));
    endtask

    task automatic clean(input int p, input int c);
        send_pkt(p, c, 1, 0, 0, 8'h47, 188, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (sync_loss) sync_seen++;
            if (cc_err && !hdr_valid)
                chk("cc_err_without_hdr", 80'(1), 80'(0));
            if (hdr_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_hdr", 80'(1), 80'(0));
                end else begin
                    hdr_t e;
                    hdr_t a;
                    e = sbq.pop_front();
                    a = {pid, cc, pusi, tei, cc_err, table_full,
                         pkt_count, cc_err_count, tei_count};
                    chk("hdr", 80'(a), 80'(e));
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int pool[10];
    int p, c, r, cut;
    logic [7:0] sb;

    initial begin
        m_clear();
        in_chk = 0;
        pend_cut = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            80'({hdr_valid, pid, cc, pusi, tei, cc_err, sync_loss,
                 table_full, pkt_count, cc_err_count, tei_count}),
            80'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) clean(13'h100, i);
        drain("clean4");
        chk("clean4_pkt_count", 80'(pkt_count), 80'(4));
        chk("clean4_pid", 80'(pid), 80'(13'h100));
        chk("clean4_err_count", 80'(cc_err_count), 80'(0));

        pulse_clr();
        clean(13'h100, 5);
        clean(13'h100, 6);
        clean(13'h100, 6);
        clean(13'h100, 6);
        drain("dup");
        chk("dup_err_count", 80'(cc_err_count), 80'(1));

        clean(13'h300, 14);
        clean(13'h300, 15);
        clean(13'h300, 0);
        drain("wrap");
        chk("wrap_err_count", 80'(cc_err_count), 80'(1));
        clean(13'h200, 3);
        send_pkt(13'h200, 4, 2, 0, 0, 8'h47, 188, 0);
        drain("afc10");
        chk("afc10_err_count", 80'(cc_err_count), 80'(2));

        pulse_clr();
        for (int i = 0; i < 8; i++) clean(13'h10 + i, 0);
        drain("fill8");
        chk("fill8_not_full", 80'(table_full), 80'(0));
        clean(13'h18, 0);
        drain("fill9");
        chk("fill9_full", 80'(table_full), 80'(1));
        chk("fill9_no_err", 80'(cc_err_count), 80'(0));
        send_pkt(13'h1FFF, 7, 1, 1, 1, 8'h47, 188, 0);
        clean(13'h10, 1);
        drain("null");
        chk("null_pkt_count", 80'(pkt_count), 80'(11));

        pulse_clr();
        clean(13'h20, 0);
        clean(13'h20, 1);
        send_pkt(13'h20, 2, 1, 0, 0, 8'h46, 188, 0);
        drain("badsync");
        chk("badsync_pkt_count", 80'(pkt_count), 80'(2));
        clean(13'h20, 2);
        drain("resync");

        send_pkt(13'h21, 0, 1, 0, 1, 8'h47, 100, 0);
        clean(13'h21, 1);
        drain("cut");
        send_pkt(13'h21, 2, 1, 1, 0, 8'h47, 188, 1);
        drain("clr_hdr");
        chk("clr_hdr_pkt_count", 80'(pkt_count), 80'(0));

        pulse_clr();
        for (int i = 0; i < 10; i++) pool[i] = $urandom_range(8190);
        for (int n = 0; n < 150; n++) begin
            p = ($urandom_range(11) == 0) ? 13'h1FFF : pool[$urandom_range(9)];
            c = $urandom_range(15);
            if (mcc.exists(p)) begin
                r = $urandom_range(9);
                if (r < 5) c = (mcc[p] + 1) % 16;
                else if (r < 7) c = mcc[p];
            end
            sb = ($urandom_range(19) == 0) ? 8'h46 : 8'h47;
            cut = ($urandom_range(19) == 0) ? $urandom_range(1, 187) : 188;
            send_pkt(p, c, $urandom_range(3), 1'($urandom_range(1)),
                     1'($urandom_range(1)), sb, cut,
                     $urandom_range(39) == 0);
        end
        drain("random");

        send_pkt(13'h40, 0, 1, 0, 0, 8'h47, 60, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_outputs",
            80'({hdr_valid, table_full, pkt_count, cc_err_count}), 80'(0));
        rst = 1'b1;
        m_clear();
        in_chk = 0;
        pend_cut = 0;
        clean(13'h40, 9);
        drain("after_reset");
        chk("after_reset_no_err", 80'(cc_err_count), 80'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
